// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory slice: NOP encoding and imem FSM states.
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2
  } imem_state_t;
endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM; the read register only loads on re, so the last word read is held.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory: clear sweep after reset, run-time program port,
// 1-cycle registered fetch with misalignment / range fault reporting.
module imem_sync
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int BA_W   = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [BA_W-1:0]   fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic              busy
);
  imem_state_t       state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              accept;
  logic              fault_now;
  logic              have_data_p1;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign fetch_ready = (state == RUN) && !prog_en;
  assign busy        = (state != RUN);
  assign accept      = fetch_req && fetch_ready;
  // Upper-bit check instead of a compare so addresses beyond the array never alias.
  assign fault_now   = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (ADDR_W + 2)) != '0);

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = fetch_addr[ADDR_W+1:2];
    ram_wdata = prog_wdata;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = DATA_W'(NOP_INSTR);
      end
      PROG: begin
        ram_we   = prog_we;
        ram_addr = prog_addr;
      end
      RUN:     ram_re = accept && !fault_now;
      default: ;
    endcase
  end

  imem_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // p0 -> p1: request accepted this cycle, response registered for next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      fetch_valid  <= 1'b0;
      fetch_fault  <= 1'b0;
      have_data_p1 <= 1'b0;
    end else begin
      fetch_valid <= accept;
      if (accept) begin
        fetch_fault <= fault_now;
        if (!fault_now) have_data_p1 <= 1'b1;
      end
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= prog_en ? PROG : RUN;
        end
        RUN:     if (prog_en) state <= PROG;
        PROG:    if (!prog_en) state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

  // RAM read register is not reset; gate it until a real word has been fetched.
  assign fetch_instr = (have_data_p1 && !fetch_fault) ? ram_rdata : DATA_W'(NOP_INSTR);
endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync: behavioural model for the DEPTH=64 instance plus literal checks,
// and a second DEPTH=256 instance for the large-depth boundary.
module tb_imem_sync;
  localparam int DW = 32;
  localparam int D1 = 64;
  localparam int D2 = 256;
  localparam int BA = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fetch_req;
  logic [BA-1:0] fetch_addr;
  logic          fetch_ready, fetch_valid, fetch_fault, busy;
  logic [DW-1:0] fetch_instr;
  logic          prog_en, prog_we;
  logic [5:0]    prog_addr;
  logic [DW-1:0] prog_wdata;

  logic          c_rst_n;
  logic          c_fetch_req;
  logic [BA-1:0] c_fetch_addr;
  logic          c_fetch_ready, c_fetch_valid, c_fetch_fault, c_busy;
  logic [DW-1:0] c_fetch_instr;
  logic          c_prog_en, c_prog_we;
  logic [7:0]    c_prog_addr;
  logic [DW-1:0] c_prog_wdata;

  int checks = 0;
  int failures = 0;

  imem_sync #(.DATA_W(DW), .DEPTH(D1), .BA_W(BA)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy)
  );

  imem_sync #(.DATA_W(DW), .DEPTH(D2), .BA_W(BA)) dut_big (
    .clk(clk), .rst_n(c_rst_n), .fetch_req(c_fetch_req), .fetch_addr(c_fetch_addr),
    .fetch_ready(c_fetch_ready), .fetch_valid(c_fetch_valid), .fetch_instr(c_fetch_instr),
    .fetch_fault(c_fetch_fault), .prog_en(c_prog_en), .prog_we(c_prog_we),
    .prog_addr(c_prog_addr), .prog_wdata(c_prog_wdata), .busy(c_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: clear countdown, program-mode flag, word array.
  logic [DW-1:0] mmem [D1];
  int            clr_left;
  bit            prog_m;
  logic          m_valid, m_fault;
  logic [DW-1:0] m_instr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left <= D1;
      prog_m   <= 1'b0;
      m_valid  <= 1'b0;
      m_instr  <= '0;
      m_fault  <= 1'b0;
    end else if (clr_left > 0) begin
      mmem[D1 - clr_left] <= '0;
      clr_left <= clr_left - 1;
      if (clr_left == 1) prog_m <= prog_en;
      m_valid <= 1'b0;
    end else if (prog_m) begin
      if (prog_we) mmem[prog_addr] <= prog_wdata;
      prog_m  <= prog_en;
      m_valid <= 1'b0;
    end else begin
      m_valid <= fetch_req && !prog_en;
      if (fetch_req && !prog_en) begin
        if ((fetch_addr % 4) != 0 || fetch_addr >= D1 * 4) begin
          m_fault <= 1'b1;
          m_instr <= '0;
        end else begin
          m_fault <= 1'b0;
          m_instr <= mmem[fetch_addr / 4];
        end
      end
      prog_m <= prog_en;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, (clr_left > 0 || prog_m));
    check("ready", fetch_ready, (clr_left == 0 && !prog_m && !prog_en));
    check("valid", fetch_valid, m_valid);
    check("instr", fetch_instr, m_instr);
    check("fault", fetch_fault, m_fault);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_clear_big(output int n);
    n = 0;
    while (c_busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    c_rst_n = 1'b1; c_fetch_req = 1'b0; c_fetch_addr = '0;
    c_prog_en = 1'b0; c_prog_we = 1'b0; c_prog_addr = '0; c_prog_wdata = '0;
    #2;
    rst_n = 1'b0;
    c_rst_n = 1'b0;
    // write strobe held through the whole sweep must be ignored
    prog_we = 1'b1; prog_addr = 6'd5; prog_wdata = 32'hdeadbeef;
    tick();
    check("rst_busy", busy, 1);
    check("rst_ready", fetch_ready, 0);
    check("rst_valid", fetch_valid, 0);
    check("rst_instr", fetch_instr, 0);
    tick();

    // Test 1: sweep length and first fetch
    rst_n = 1'b1;
    wait_clear(n);
    check("clear_cycles", n, 64);
    check("ready_after_clear", fetch_ready, 1);
    prog_we = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    check("t1_valid", fetch_valid, 1);
    check("t1_instr", fetch_instr, 32'h0);
    check("t1_fault", fetch_fault, 0);
    fetch_addr = 32'h14;
    tick();
    check("clear_we_ignored", fetch_instr, 32'h0);
    fetch_req = 1'b0;

    // Test 2: program three words, last write with prog_en falling
    prog_en = 1'b1;
    tick();
    check("t2_busy_prog", busy, 1);
    check("t2_ready_prog", fetch_ready, 0);
    prog_we = 1'b1; prog_addr = 6'd0;  prog_wdata = 32'h20020005; tick();
    prog_addr = 6'd1;  prog_wdata = 32'h2003000c; tick();
    prog_addr = 6'd17; prog_wdata = 32'hac020054; prog_en = 1'b0; tick();
    prog_we = 1'b0;
    check("t2_run", busy, 0);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    check("t2_i0", fetch_instr, 32'h20020005);
    fetch_addr = 32'h4;
    tick();
    check("t2_i1", fetch_instr, 32'h2003000c);
    check("t2_v1", fetch_valid, 1);
    fetch_addr = 32'h44;
    tick();
    check("t2_i2", fetch_instr, 32'hac020054);
    check("t2_f2", fetch_fault, 0);
    fetch_req = 1'b0;
    tick();
    check("t2_idle_valid", fetch_valid, 0);
    check("t2_hold_instr", fetch_instr, 32'hac020054);

    // Test 3: misaligned and out-of-range faults
    fetch_req = 1'b1; fetch_addr = 32'h6;
    tick();
    check("t3_mis_fault", fetch_fault, 1);
    check("t3_mis_instr", fetch_instr, 32'h0);
    fetch_addr = 32'h100;
    tick();
    check("t3_oor_fault", fetch_fault, 1);
    check("t3_oor_instr", fetch_instr, 32'h0);
    check("t3_oor_valid", fetch_valid, 1);
    fetch_addr = 32'h4;
    tick();
    check("t3_after_instr", fetch_instr, 32'h2003000c);
    check("t3_after_fault", fetch_fault, 0);
    fetch_req = 1'b0;

    // Test 4: fetch accepted the cycle before prog_en rises still completes
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0; prog_en = 1'b1;
    #1;
    check("t4_ready_low", fetch_ready, 0);
    check("t4_valid", fetch_valid, 1);
    check("t4_instr", fetch_instr, 32'h20020005);
    tick();
    check("t4_prog_busy", busy, 1);
    check("t4_valid_drop", fetch_valid, 0);

    // Test 5b: reset with a fetch in flight
    prog_we = 1'b1; prog_addr = 6'd0; prog_wdata = 32'h11111111; prog_en = 1'b0;
    tick();
    prog_we = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    check("t5_pre_instr", fetch_instr, 32'h11111111);
    check("t5_pre_valid", fetch_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_flight_valid", fetch_valid, 0);
    check("t5_flight_busy", busy, 1);
    tick();
    rst_n = 1'b1;
    // Test 5a: sweep straight into PROG, then reset mid-PROG
    prog_en = 1'b1;
    repeat (64) tick();
    check("t5_clear_to_prog", busy, 1);
    prog_we = 1'b1; prog_addr = 6'd1; prog_wdata = 32'h22222222;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_prog_rst_busy", busy, 1);
    check("t5_prog_rst_valid", fetch_valid, 0);
    prog_we = 1'b0; prog_en = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_clear(n);
    check("t5_clear_cycles", n, 64);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    check("t5_w0_cleared", fetch_instr, 32'h0);
    fetch_addr = 32'h4;
    tick();
    check("t5_w1_cleared", fetch_instr, 32'h0);
    fetch_addr = 32'h44;
    tick();
    check("t5_w17_cleared", fetch_instr, 32'h0);
    fetch_req = 1'b0;

    // Test 6: DEPTH=256 instance, top word and first out-of-range address
    c_rst_n = 1'b1;
    wait_clear_big(n);
    check("t6_clear_cycles", n, 256);
    c_prog_en = 1'b1;
    tick();
    c_prog_we = 1'b1; c_prog_addr = 8'd255; c_prog_wdata = 32'hcafef00d; c_prog_en = 1'b0;
    tick();
    c_prog_we = 1'b0;
    c_fetch_req = 1'b1; c_fetch_addr = 32'h3fc;
    tick();
    check("t6_top_valid", c_fetch_valid, 1);
    check("t6_top_instr", c_fetch_instr, 32'hcafef00d);
    check("t6_top_fault", c_fetch_fault, 0);
    c_fetch_addr = 32'h400;
    tick();
    check("t6_oor_fault", c_fetch_fault, 1);
    check("t6_oor_instr", c_fetch_instr, 32'h0);
    c_fetch_addr = 32'h3f8;
    tick();
    check("t6_w254", c_fetch_instr, 32'h0);
    check("t6_w254_fault", c_fetch_fault, 0);
    c_fetch_req = 1'b0;
    tick();
    check("t6_idle_valid", c_fetch_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
